// File: rtl/exu_lsu_if.sv
// exu_lsu_if: bundles the ALU-side request, the req/gnt/rvalid data bus and
// the writeback beat of the load/store unit.
// slave  = the load/store unit itself.
// master = the surrounding pipeline and memory (drives the LSU inputs).
interface exu_lsu_if #(
  parameter int ADDR_W = 32
);
  logic              i_valid;
  logic              i_mem_wen;
  logic              i_mem_ren;
  logic [ADDR_W-1:0] i_mem_addr;
  logic [31:0]       i_wdata;
  logic [2:0]        i_funct3;
  logic              i_rd_wen;
  logic [4:0]        i_rd_addr;
  logic [31:0]       i_result;
  logic              o_stall;
  logic              o_dbus_req;
  logic              o_dbus_we;
  logic [ADDR_W-1:0] o_dbus_addr;
  logic [3:0]        o_dbus_be;
  logic [31:0]       o_dbus_wdata;
  logic              i_dbus_gnt;
  logic              i_dbus_rvalid;
  logic [31:0]       i_dbus_rdata;
  logic              o_wb_valid;
  logic              o_wb_rd_wen;
  logic [4:0]        o_wb_rd_addr;
  logic [31:0]       o_wb_data;
  logic              o_misalign;

  modport slave (
    input  i_valid, i_mem_wen, i_mem_ren, i_mem_addr, i_wdata, i_funct3,
           i_rd_wen, i_rd_addr, i_result, i_dbus_gnt, i_dbus_rvalid, i_dbus_rdata,
    output o_stall, o_dbus_req, o_dbus_we, o_dbus_addr, o_dbus_be, o_dbus_wdata,
           o_wb_valid, o_wb_rd_wen, o_wb_rd_addr, o_wb_data, o_misalign
  );

  modport master (
    output i_valid, i_mem_wen, i_mem_ren, i_mem_addr, i_wdata, i_funct3,
           i_rd_wen, i_rd_addr, i_result, i_dbus_gnt, i_dbus_rvalid, i_dbus_rdata,
    input  o_stall, o_dbus_req, o_dbus_we, o_dbus_addr, o_dbus_be, o_dbus_wdata,
           o_wb_valid, o_wb_rd_wen, o_wb_rd_addr, o_wb_data, o_misalign
  );
endinterface

// File: rtl/exu_lsu.sv
// exu_lsu: load/store unit. Accepts a memory op from the ALU/AGU, runs one
// req/gnt(/rvalid) data bus transaction, formats store lanes, aligns and
// extends load data, and returns one writeback beat per op. Non-memory ops
// pass straight through to writeback in the same cycle.
// Optional feature macro: LSU_MISALIGN_CHK_EN (misaligned H/W accesses skip
// the bus and return a beat flagged with o_misalign).
module exu_lsu #(
  parameter int ADDR_W = 32
) (
  input logic    i_clk,
  input logic    i_rst,
  exu_lsu_if.slave lsu
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t            state;
  logic              req_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        be_q;
  logic [31:0]       wdata_q;
  logic [2:0]        f3_q;
  logic [1:0]        off_q;
  logic              rd_wen_q;
  logic [4:0]        rd_addr_q;
  logic [31:0]       ld_data_q;
  logic              mem_op;
  logic              accept;
`ifdef LSU_MISALIGN_CHK_EN
  logic              misalign_q;
`endif

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   store_be = 4'b0001 << off;
      2'b01:   store_be = off[1] ? 4'b1100 : 4'b0011;
      default: store_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] w);
    case (f3[1:0])
      2'b00:   store_data = {4{w[7:0]}};
      2'b01:   store_data = {2{w[15:0]}};
      default: store_data = w;
    endcase
  endfunction

  function automatic logic [31:0] load_align(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    b = rdata[8*off +: 8];
    h = off[1] ? rdata[31:16] : rdata[15:0];
    case (f3)
      3'b000:  load_align = {{24{b[7]}}, b};
      3'b100:  load_align = {24'h0, b};
      3'b001:  load_align = {{16{h[15]}}, h};
      3'b101:  load_align = {16'h0, h};
      default: load_align = rdata;
    endcase
  endfunction

`ifdef LSU_MISALIGN_CHK_EN
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    is_misaligned = ((f3[1:0] == 2'b01) && off[0]) || ((f3[1:0] == 2'b10) && (off != 2'b00));
  endfunction
`endif

  assign mem_op = lsu.i_mem_wen | lsu.i_mem_ren;
  assign accept = (state == IDLE) && lsu.i_valid && mem_op && !i_rst;

  // Access FSM: latches the op at acceptance and sequences the bus handshake
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      be_q      <= 4'h0;
      wdata_q   <= 32'h0;
      rd_wen_q  <= 1'b0;
      ld_data_q <= 32'h0;
`ifdef LSU_MISALIGN_CHK_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            we_q      <= lsu.i_mem_wen;
            addr_q    <= {lsu.i_mem_addr[ADDR_W-1:2], 2'b00};
            be_q      <= store_be(lsu.i_funct3, lsu.i_mem_addr[1:0]);
            wdata_q   <= store_data(lsu.i_funct3, lsu.i_wdata);
            f3_q      <= lsu.i_funct3;
            off_q     <= lsu.i_mem_addr[1:0];
            rd_wen_q  <= lsu.i_rd_wen;
            rd_addr_q <= lsu.i_rd_addr;
            ld_data_q <= 32'h0;
`ifdef LSU_MISALIGN_CHK_EN
            if (is_misaligned(lsu.i_funct3, lsu.i_mem_addr[1:0])) begin
              misalign_q <= 1'b1;
              state      <= DONE;
            end else begin
              req_q <= 1'b1;
              state <= REQ;
            end
`else
            req_q <= 1'b1;
            state <= REQ;
`endif
          end
        end
        REQ: begin
          if (lsu.i_dbus_gnt) begin
            req_q <= 1'b0;
            state <= we_q ? DONE : WAIT;
          end
        end
        WAIT: begin
          if (lsu.i_dbus_rvalid) begin
            ld_data_q <= load_align(f3_q, off_q, lsu.i_dbus_rdata);
            state     <= DONE;
          end
        end
        default: begin
`ifdef LSU_MISALIGN_CHK_EN
          misalign_q <= 1'b0;
`endif
          state <= IDLE;
        end
      endcase
    end
  end

  assign lsu.o_dbus_req   = req_q;
  assign lsu.o_dbus_we    = we_q;
  assign lsu.o_dbus_addr  = addr_q;
  assign lsu.o_dbus_be    = be_q;
  assign lsu.o_dbus_wdata = wdata_q;
  assign lsu.o_stall      = (state == REQ) || (state == WAIT) || accept;
`ifdef LSU_MISALIGN_CHK_EN
  assign lsu.o_misalign   = (state == DONE) && misalign_q;
`else
  assign lsu.o_misalign   = 1'b0;
`endif

  // Writeback mux: same-cycle passthrough in IDLE, registered beat in DONE
  always_comb begin
    lsu.o_wb_valid   = 1'b0;
    lsu.o_wb_rd_wen  = 1'b0;
    lsu.o_wb_rd_addr = 5'd0;
    lsu.o_wb_data    = 32'h0;
    if (state == DONE) begin
      lsu.o_wb_valid   = 1'b1;
      lsu.o_wb_rd_addr = rd_addr_q;
      lsu.o_wb_data    = ld_data_q;
`ifdef LSU_MISALIGN_CHK_EN
      lsu.o_wb_rd_wen  = rd_wen_q && !we_q && !misalign_q;
`else
      lsu.o_wb_rd_wen  = rd_wen_q && !we_q;
`endif
    end else if ((state == IDLE) && lsu.i_valid && !mem_op && !i_rst) begin
      lsu.o_wb_valid   = 1'b1;
      lsu.o_wb_rd_wen  = lsu.i_rd_wen;
      lsu.o_wb_rd_addr = lsu.i_rd_addr;
      lsu.o_wb_data    = lsu.i_result;
    end
  end

endmodule

// File: tb/tb_exu_lsu.sv
// tb_exu_lsu: directed bench for exu_lsu with hand-computed expectations.
module tb_exu_lsu;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  exu_lsu_if #(.ADDR_W(32)) bus ();

  exu_lsu #(.ADDR_W(32)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .lsu   (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_valid = 0; bus.i_mem_wen = 0; bus.i_mem_ren = 0; bus.i_mem_addr = 0;
    bus.i_wdata = 0; bus.i_funct3 = 0; bus.i_rd_wen = 0; bus.i_rd_addr = 0;
    bus.i_result = 0; bus.i_dbus_gnt = 0; bus.i_dbus_rvalid = 0; bus.i_dbus_rdata = 0;
  endtask

  // Load with immediate gnt and rvalid on the following cycle.
  task automatic do_load(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                         input logic [31:0] rdata, input logic [31:0] exp);
    bus.i_valid = 1; bus.i_mem_ren = 1; bus.i_mem_addr = addr; bus.i_funct3 = f3;
    bus.i_rd_wen = 1; bus.i_rd_addr = 5'd7;
    #1;
    check({tag, "_stall_idle"}, 32'(bus.o_stall), 32'd1);
    tick();
    idle_inputs();
    check({tag, "_req"}, 32'(bus.o_dbus_req), 32'd1);
    check({tag, "_addr"}, bus.o_dbus_addr, {addr[31:2], 2'b00});
    bus.i_dbus_gnt = 1;
    tick();
    bus.i_dbus_gnt = 0;
    check({tag, "_req_wait"}, 32'(bus.o_dbus_req), 32'd0);
    check({tag, "_stall_wait"}, 32'(bus.o_stall), 32'd1);
    bus.i_dbus_rvalid = 1; bus.i_dbus_rdata = rdata;
    tick();
    bus.i_dbus_rvalid = 0;
    check({tag, "_wb_valid"}, 32'(bus.o_wb_valid), 32'd1);
    check({tag, "_wb_data"}, bus.o_wb_data, exp);
    check({tag, "_wb_rd_wen"}, 32'(bus.o_wb_rd_wen), 32'd1);
    check({tag, "_wb_rd_addr"}, 32'(bus.o_wb_rd_addr), 32'd7);
    check({tag, "_stall_done"}, 32'(bus.o_stall), 32'd0);
    tick();
    check({tag, "_wb_after"}, 32'(bus.o_wb_valid), 32'd0);
  endtask

  // Store with gnt delayed by gnt_delay cycles.
  task automatic do_store(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                          input logic [31:0] wdata, input int gnt_delay,
                          input logic [3:0] exp_be, input logic [31:0] exp_wdata);
    bus.i_valid = 1; bus.i_mem_wen = 1; bus.i_mem_addr = addr; bus.i_funct3 = f3;
    bus.i_wdata = wdata; bus.i_rd_wen = 1; bus.i_rd_addr = 5'd9;
    tick();
    idle_inputs();
    check({tag, "_we"}, 32'(bus.o_dbus_we), 32'd1);
    check({tag, "_be"}, 32'(bus.o_dbus_be), 32'(exp_be));
    check({tag, "_wdata"}, bus.o_dbus_wdata, exp_wdata);
    check({tag, "_addr"}, bus.o_dbus_addr, {addr[31:2], 2'b00});
    for (int i = 0; i < gnt_delay; i++) begin
      tick();
      check({tag, "_req_held"}, 32'(bus.o_dbus_req), 32'd1);
      check({tag, "_stall_held"}, 32'(bus.o_stall), 32'd1);
      check({tag, "_be_held"}, 32'(bus.o_dbus_be), 32'(exp_be));
    end
    bus.i_dbus_gnt = 1;
    tick();
    bus.i_dbus_gnt = 0;
    check({tag, "_wb_valid"}, 32'(bus.o_wb_valid), 32'd1);
    check({tag, "_wb_rd_wen"}, 32'(bus.o_wb_rd_wen), 32'd0);
    check({tag, "_stall_done"}, 32'(bus.o_stall), 32'd0);
    check({tag, "_req_done"}, 32'(bus.o_dbus_req), 32'd0);
    tick();
    check({tag, "_wb_after"}, 32'(bus.o_wb_valid), 32'd0);
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
    check("rst_stall", 32'(bus.o_stall), 32'd0);
    check("rst_req", 32'(bus.o_dbus_req), 32'd0);
    check("rst_we", 32'(bus.o_dbus_we), 32'd0);
    check("rst_be", 32'(bus.o_dbus_be), 32'd0);
    check("rst_addr", bus.o_dbus_addr, 32'd0);
    check("rst_wdata", bus.o_dbus_wdata, 32'd0);
    check("rst_wb_valid", 32'(bus.o_wb_valid), 32'd0);
    check("rst_misalign", 32'(bus.o_misalign), 32'd0);

    // Non-memory passthrough
    bus.i_valid = 1; bus.i_result = 32'h1234; bus.i_rd_wen = 1; bus.i_rd_addr = 5'd5;
    #1;
    check("pass_wb_valid", 32'(bus.o_wb_valid), 32'd1);
    check("pass_wb_data", bus.o_wb_data, 32'h1234);
    check("pass_rd_addr", 32'(bus.o_wb_rd_addr), 32'd5);
    check("pass_rd_wen", 32'(bus.o_wb_rd_wen), 32'd1);
    check("pass_stall", 32'(bus.o_stall), 32'd0);
    check("pass_req", 32'(bus.o_dbus_req), 32'd0);
    tick();
    idle_inputs();
    check("pass_req_next", 32'(bus.o_dbus_req), 32'd0);

    // Loads
    do_load("lw", 32'h100, 3'b010, 32'hDEADBEEF, 32'hDEADBEEF);
    check("lw_be", 32'(bus.o_dbus_be), 32'hF);
    do_load("lb", 32'h103, 3'b000, 32'h80123456, 32'hFFFFFF80);
    do_load("lbu", 32'h103, 3'b100, 32'h80123456, 32'h00000080);
    do_load("lhu", 32'h102, 3'b101, 32'hBEEF1234, 32'h0000BEEF);
    do_load("lh_hi", 32'h102, 3'b001, 32'hBEEF1234, 32'hFFFFBEEF);
    do_load("lh_lo", 32'h100, 3'b001, 32'h1234F00D, 32'hFFFFF00D);
    do_load("lb_1", 32'h101, 3'b000, 32'h12345678, 32'h00000056);

    // Stores
    do_store("sb", 32'h101, 3'b000, 32'h000000AB, 3, 4'b0010, 32'hABABABAB);
    do_store("sh", 32'h102, 3'b001, 32'h0000BEEF, 0, 4'b1100, 32'hBEEFBEEF);
    do_store("sw", 32'h104, 3'b010, 32'hCAFEF00D, 1, 4'b1111, 32'hCAFEF00D);

    // Reset in WAIT, late rvalid ignored
    bus.i_valid = 1; bus.i_mem_ren = 1; bus.i_mem_addr = 32'h200; bus.i_funct3 = 3'b010;
    bus.i_rd_wen = 1; bus.i_rd_addr = 5'd3;
    tick();
    idle_inputs();
    bus.i_dbus_gnt = 1;
    tick();
    bus.i_dbus_gnt = 0;
    rst = 1;
    tick();
    rst = 0;
    bus.i_dbus_rvalid = 1; bus.i_dbus_rdata = 32'h55AA55AA;
    #1;
    check("rstw_req", 32'(bus.o_dbus_req), 32'd0);
    check("rstw_wb", 32'(bus.o_wb_valid), 32'd0);
    check("rstw_stall", 32'(bus.o_stall), 32'd0);
    tick();
    bus.i_dbus_rvalid = 0;
    check("rstw_wb_next", 32'(bus.o_wb_valid), 32'd0);
    check("rstw_req_next", 32'(bus.o_dbus_req), 32'd0);

    // Misaligned word access
`ifdef LSU_MISALIGN_CHK_EN
    bus.i_valid = 1; bus.i_mem_ren = 1; bus.i_mem_addr = 32'h102; bus.i_funct3 = 3'b010;
    bus.i_rd_wen = 1; bus.i_rd_addr = 5'd4;
    tick();
    idle_inputs();
    check("mis_req", 32'(bus.o_dbus_req), 32'd0);
    check("mis_wb_valid", 32'(bus.o_wb_valid), 32'd1);
    check("mis_flag", 32'(bus.o_misalign), 32'd1);
    check("mis_rd_wen", 32'(bus.o_wb_rd_wen), 32'd0);
    tick();
    check("mis_after", 32'(bus.o_misalign), 32'd0);
`else
    do_load("lw_off", 32'h102, 3'b010, 32'h01234567, 32'h01234567);
    check("lw_off_be", 32'(bus.o_dbus_be), 32'hF);
    check("lw_off_mis", 32'(bus.o_misalign), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
